conta_sweep_ctrl: RTL and testbench

CONTA_SWEEP_CTRL -- requirements
Module: conta_sweep_ctrl

---
 rtl/conta_sweep_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_conta_sweep_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/conta_sweep_ctrl.sv
// ============================================================================
// Module   : conta_sweep_ctrl
// Purpose  : Sweep sequencer driving an external up/down counter; keeps a
//            shadow copy of the count and registers every output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conta_sweep_ctrl #(
    parameter int WIDTH = 3,
    parameter int NW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [NW-1:0]    n_sweeps,
    output logic             cnt_en,
    output logic             cnt_up,
    output logic             cnt_clr,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_CLR    = 3'd1;
    localparam logic [2:0] c_SEEK   = 3'd2;
    localparam logic [2:0] c_RUN_UP = 3'd3;
    localparam logic [2:0] c_RUN_DN = 3'd4;
    localparam logic [2:0] c_REWIND = 3'd5;
    localparam logic [2:0] c_DONE   = 3'd6;

    localparam logic [1:0] c_M_UP  = 2'b00;
    localparam logic [1:0] c_M_DN  = 2'b01;
    localparam logic [1:0] c_M_TRI = 2'b10;

    logic [2:0]       r_state, w_state_nxt;
    logic [1:0]       r_mode, w_mode_nxt;
    logic [WIDTH-1:0] r_lo, w_lo_nxt, r_hi, w_hi_nxt;
    logic [NW-1:0]    r_rem, w_rem_nxt;
    logic [WIDTH-1:0] r_q, w_q_nxt;
    logic             r_cnt_en, r_cnt_up, r_cnt_clr, r_busy, r_done, r_err;
    logic             w_en_nxt, w_up_nxt, w_clr_nxt, w_busy_nxt, w_done_nxt, w_err_nxt;
    logic             w_busy_now, w_sweep_end;
    logic [WIDTH-1:0] w_seek_tgt, w_rew_tgt;

    assign w_seek_tgt = (r_mode == c_M_DN) ? r_hi : r_lo;
    assign w_rew_tgt  = (r_mode == c_M_UP) ? r_lo : r_hi;
    assign w_busy_now = (r_state == c_CLR) || (r_state == c_SEEK) || (r_state == c_RUN_UP) ||
                        (r_state == c_RUN_DN) || (r_state == c_REWIND);

    // Shadow count follows the command that is on the wires this cycle; an abort freezes it.
    always_comb begin
        w_q_nxt = r_q;
        if (w_busy_now && stop)
            w_q_nxt = r_q;
        else if (r_cnt_clr)
            w_q_nxt = '0;
        else if (r_cnt_en)
            w_q_nxt = r_cnt_up ? r_q + WIDTH'(1) : r_q - WIDTH'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= c_IDLE;
            r_mode    <= '0;
            r_lo      <= '0;
            r_hi      <= '0;
            r_rem     <= '0;
            r_q       <= '0;
            r_cnt_en  <= 1'b0;
            r_cnt_up  <= 1'b0;
            r_cnt_clr <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_mode    <= w_mode_nxt;
            r_lo      <= w_lo_nxt;
            r_hi      <= w_hi_nxt;
            r_rem     <= w_rem_nxt;
            r_q       <= w_q_nxt;
            r_cnt_en  <= w_en_nxt;
            r_cnt_up  <= w_up_nxt;
            r_cnt_clr <= w_clr_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_lo_nxt    = r_lo;
        w_hi_nxt    = r_hi;
        w_rem_nxt   = r_rem;
        w_err_nxt   = 1'b0;
        w_sweep_end = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (start && !stop) begin
                    if ((lo > hi) || (mode == 2'b11) || (n_sweeps == '0)) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_mode_nxt  = mode;
                        w_lo_nxt    = lo;
                        w_hi_nxt    = hi;
                        w_rem_nxt   = n_sweeps;
                        w_state_nxt = c_CLR;
                    end
                end
            end
            c_CLR:  w_state_nxt = c_SEEK;
            c_SEEK: begin
                if (r_q == w_seek_tgt)
                    w_state_nxt = (r_mode == c_M_DN) ? c_RUN_DN : c_RUN_UP;
            end
            c_RUN_UP: begin
                if (r_q == r_hi) begin
                    if (r_mode == c_M_TRI)
                        w_state_nxt = c_RUN_DN;
                    else
                        w_sweep_end = 1'b1;
                end
            end
            c_RUN_DN: begin
                if (r_q == r_lo)
                    w_sweep_end = 1'b1;
            end
            c_REWIND: begin
                if (r_q == w_rew_tgt)
                    w_state_nxt = (r_mode == c_M_UP) ? c_RUN_UP : c_RUN_DN;
            end
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase

        if (w_sweep_end) begin
            if (r_rem == NW'(1)) begin
                w_state_nxt = c_DONE;
            end else begin
                w_rem_nxt   = r_rem - NW'(1);
                w_state_nxt = (r_mode == c_M_TRI) ? c_RUN_UP : c_REWIND;
            end
        end

        if (w_busy_now && stop)
            w_state_nxt = c_IDLE;
    end

    // Outputs are decided for the state and count that will hold after this edge.
    always_comb begin
        w_en_nxt   = 1'b0;
        w_up_nxt   = 1'b0;
        w_clr_nxt  = (w_state_nxt == c_CLR);
        w_done_nxt = (w_state_nxt == c_DONE);
        w_busy_nxt = (w_state_nxt == c_CLR) || (w_state_nxt == c_SEEK) ||
                     (w_state_nxt == c_RUN_UP) || (w_state_nxt == c_RUN_DN) ||
                     (w_state_nxt == c_REWIND);
        case (w_state_nxt)
            c_SEEK: begin
                w_en_nxt = (w_q_nxt != w_seek_tgt);
                w_up_nxt = w_en_nxt;
            end
            c_RUN_UP: begin
                w_en_nxt = (w_q_nxt != r_hi);
                w_up_nxt = w_en_nxt;
            end
            c_RUN_DN: begin
                w_en_nxt = (w_q_nxt != r_lo);
                w_up_nxt = 1'b0;
            end
            c_REWIND: begin
                w_en_nxt = (w_q_nxt != w_rew_tgt);
                w_up_nxt = w_en_nxt && (r_mode == c_M_DN);
            end
            default: begin
                w_en_nxt = 1'b0;
                w_up_nxt = 1'b0;
            end
        endcase
    end

    assign cnt_en  = r_cnt_en;
    assign cnt_up  = r_cnt_up;
    assign cnt_clr = r_cnt_clr;
    assign q       = r_q;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_conta_sweep_ctrl.sv
// ============================================================================
// Module   : tb_conta_sweep_ctrl
// Purpose  : Self-checking bench for conta_sweep_ctrl against a cycle-list model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conta_sweep_ctrl;

    logic       clk = 1'b0;
    logic       reset, start, stop;
    logic [1:0] mode;
    logic [2:0] lo, hi;
    logic [3:0] n_sweeps;
    logic       cnt_en, cnt_up, cnt_clr, busy, done, err;
    logic [2:0] q;

    int n_cmp   = 0;
    int n_bad   = 0;
    int model_q = 0;
    logic [8:0] exp_q[$];

    conta_sweep_ctrl #(.WIDTH(3), .NW(4)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
        .lo(lo), .hi(hi), .n_sweeps(n_sweeps), .cnt_en(cnt_en), .cnt_up(cnt_up),
        .cnt_clr(cnt_clr), .q(q), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] obs();
        return {q, cnt_en, cnt_up, cnt_clr, busy, done, err};
    endfunction

    function automatic void push(int qv, bit en, bit up, bit clr, bit bsy, bit dn);
        exp_q.push_back({3'(qv), en, up, clr, bsy, dn, 1'b0});
    endfunction

    // Expected per-cycle view of a whole legal sequence, starting with the clear cycle.
    task automatic build(input int m, input int l, input int h, input int n);
        int t;
        exp_q.delete();
        push(model_q, 0, 0, 1, 1, 0);
        t = (m == 1) ? h : l;
        for (int v = 0; v <= t; v++) push(v, v != t, v != t, 0, 1, 0);
        for (int s = 0; s < n; s++) begin
            if (m == 2) begin
                for (int v = l; v <= h; v++) push(v, v != h, v != h, 0, 1, 0);
                for (int v = h; v >= l; v--) push(v, v != l, 0, 0, 1, 0);
            end else if (m == 0) begin
                if (s > 0) for (int v = h; v >= l; v--) push(v, v != l, 0, 0, 1, 0);
                for (int v = l; v <= h; v++) push(v, v != h, v != h, 0, 1, 0);
            end else begin
                if (s > 0) for (int v = l; v <= h; v++) push(v, v != h, v != h, 0, 1, 0);
                for (int v = h; v >= l; v--) push(v, v != l, 0, 0, 1, 0);
            end
        end
        t = (m == 0) ? h : l;
        push(t, 0, 0, 0, 0, 1);
        push(t, 0, 0, 0, 0, 0);
        model_q = t;
    endtask

    task automatic run_check(input string name, input int m, input int l, input int h,
                             input int n, input bit hold);
        build(m, l, h, n);
        mode = 2'(m); lo = 3'(l); hi = 3'(h); n_sweeps = 4'(n);
        start = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk); #1;
            if (!hold) start = 1'b0;
            n_cmp++;
            if (obs() !== exp_q[i]) begin
                n_bad++;
                $display("FAIL %s cyc%0d: got q=%0d en,up,clr,busy,done,err=%b want q=%0d %b",
                         name, i, obs() >> 6, obs() & 9'h3f, exp_q[i] >> 6, exp_q[i] & 9'h3f);
            end
            n_cmp++;
            if ((cnt_up && !cnt_en) || (cnt_en && cnt_up && q == 3'd7) ||
                (cnt_en && !cnt_up && q == 3'd0)) begin
                n_bad++;
                $display("FAIL %s_proto cyc%0d: got q=%0d en=%b up=%b want no wrap, up only with en",
                         name, i, q, cnt_en, cnt_up);
            end
        end
    endtask

    task automatic expect_vec(input string name, input logic [8:0] want);
        n_cmp++;
        if (obs() !== want) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", name, obs(), want);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; stop = 1'b0;
        mode = 2'b00; lo = 3'd0; hi = 3'd0; n_sweeps = 4'd0;
        #2;
        expect_vec("reset_now", 9'd0);
        start = 1'b1; lo = 3'd1; hi = 3'd2; n_sweeps = 4'd1;
        repeat (2) @(posedge clk);
        #1;
        expect_vec("reset_held", 9'd0);
        reset = 1'b1;
        start = 1'b0;
        model_q = 0;
        // Start accepted on the very first edge after release.
        run_check("first_start", 0, 2, 5, 1, 0);
    endtask

    task automatic test_triangle();
        int seq[12] = '{1, 2, 3, 3, 2, 1, 1, 2, 3, 3, 2, 1};
        mode = 2'b10; lo = 3'd1; hi = 3'd3; n_sweeps = 4'd2; start = 1'b1;
        repeat (3) begin @(posedge clk); #1; start = 1'b0; end
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (q !== 3'(seq[k]) || busy !== 1'b1 || done !== 1'b0) begin
                n_bad++;
                $display("FAIL tri_q[%0d]: got q=%0d busy=%b done=%b want q=%0d busy=1 done=0",
                         k, q, busy, done, seq[k]);
            end
        end
        @(posedge clk); #1;
        expect_vec("tri_done", {3'd1, 6'b000010});
        @(posedge clk); #1;
        expect_vec("tri_idle", {3'd1, 6'b000000});
        model_q = 1;
    endtask

    task automatic test_err();
        logic [1:0] m[3] = '{2'b00, 2'b11, 2'b10};
        logic [2:0] l[3] = '{3'd5, 3'd1, 3'd1};
        logic [2:0] h[3] = '{3'd2, 3'd4, 3'd4};
        logic [3:0] n[3] = '{4'd1, 4'd1, 4'd0};
        for (int k = 0; k < 3; k++) begin
            mode = m[k]; lo = l[k]; hi = h[k]; n_sweeps = n[k]; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            expect_vec($sformatf("err_pulse%0d", k), {3'(model_q), 6'b000001});
            @(posedge clk); #1;
            expect_vec($sformatf("err_clear%0d", k), {3'(model_q), 6'b000000});
        end
    endtask

    task automatic test_start_stop_idle();
        mode = 2'b00; lo = 3'd1; hi = 3'd2; n_sweeps = 4'd1;
        start = 1'b1; stop = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            expect_vec("stop_wins_idle", {3'(model_q), 6'b000000});
        end
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic test_stop();
        mode = 2'b00; lo = 3'd2; hi = 3'd6; n_sweeps = 4'd1; start = 1'b1;
        repeat (6) begin @(posedge clk); #1; start = 1'b0; end
        expect_vec("stop_pre", {3'd3, 6'b110100});
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        expect_vec("stop_abort", {3'd3, 6'b000000});
        repeat (3) begin
            @(posedge clk); #1;
            expect_vec("stop_hold", {3'd3, 6'b000000});
        end
        model_q = 3;
    endtask

    task automatic test_async_reset();
        mode = 2'b01; lo = 3'd0; hi = 3'd7; n_sweeps = 4'd1; start = 1'b1;
        repeat (11) begin @(posedge clk); #1; start = 1'b0; end
        expect_vec("rdn_pre", {3'd6, 6'b100100});
        #2 reset = 1'b0;
        #1;
        expect_vec("async_reset", 9'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        model_q = 0;
        run_check("after_reset", 0, 1, 4, 2, 0);
    endtask

    task automatic test_back_to_back();
        run_check("b2b", 2, 0, 1, 1, 1);
        @(posedge clk); #1;
        expect_vec("b2b_restart", {3'(model_q), 6'b001100});
        start = 1'b0; stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        expect_vec("b2b_abort", {3'(model_q), 6'b000000});
    endtask

    task automatic test_random();
        int m, l, h, n;
        for (int k = 0; k < 25; k++) begin
            m = $urandom_range(0, 2);
            l = $urandom_range(0, 7);
            h = $urandom_range(l, 7);
            if ($urandom_range(0, 3) == 0) h = l;
            n = $urandom_range(1, 3);
            run_check($sformatf("rnd%0d_m%0d_%0d_%0d_n%0d", k, m, l, h, n), m, l, h, n, 0);
        end
    endtask

    initial begin
        test_reset();
        run_check("up_2_5", 0, 2, 5, 1, 0);
        test_triangle();
        run_check("down_0_7", 1, 0, 7, 2, 0);
        run_check("lohi_up", 0, 4, 4, 3, 0);
        run_check("lohi_tri", 2, 6, 6, 2, 0);
        run_check("lohi_dn", 1, 7, 7, 2, 0);
        test_err();
        test_start_stop_idle();
        test_stop();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
